// File: rtl/benes_perm_apply.sv
`timescale 1ns/1ps
// benes_perm_apply
//
// Pipelined Benes permutation datapath. It routes SIZE lanes of DATA_W-bit data through
// STAGES = 2*log2(SIZE)-1 switch stages, with one registered bank after each stage.
// Control bits are loaded through a cfg handshake and are held until the next load.
// A load is accepted only when the pipeline is empty, so in-flight vectors always see a
// single control word.
//
// Optional feature: define BENES_INV_EN to add the i_cfg_inv port and an inverse-
// permutation mode. In that mode the stage slices are used in mirrored order.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_cfg_valid       control word offered
//   o_cfg_ready       control word may be accepted (pipeline empty, no input offered)
//   i_cfg_ctrl        BITWIDTH control bits; stage s uses bits [s*SIZE/2 +: SIZE/2]
//   i_cfg_inv         (BENES_INV_EN only) apply the inverse permutation
//   i_in_valid        input vector valid
//   o_in_ready        input vector accepted when i_in_valid && o_in_ready
//   i_in_data         lane i at bits [i*DATA_W +: DATA_W]
//   o_out_valid       output vector valid
//   i_out_ready       consumer accepts
//   o_out_data        permuted vector, same lane packing
module benes_perm_apply #(
    parameter int unsigned SIZE     = 32,
    parameter int unsigned DATA_W   = 16,
    localparam int unsigned TAGWIDTH = $clog2(SIZE),
    localparam int unsigned STAGES   = 2 * TAGWIDTH - 1,
    localparam int unsigned HALF     = SIZE / 2,
    localparam int unsigned BITWIDTH = STAGES * HALF,
    localparam int unsigned VEC_W    = SIZE * DATA_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cfg_valid,
    output logic                o_cfg_ready,
    input  logic [BITWIDTH-1:0] i_cfg_ctrl,
`ifdef BENES_INV_EN
    input  logic                i_cfg_inv,
`endif
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [VEC_W-1:0]    i_in_data,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [VEC_W-1:0]    o_out_data
);

    logic [BITWIDTH-1:0] r_ctrl;
    logic [STAGES-1:0]   r_v;
    logic [VEC_W-1:0]    r_data [STAGES];

    logic w_advance;
    logic w_cfg_ready;
    logic w_cfg_take;
    logic w_in_take;

    // The whole pipeline moves as one unit. It freezes only when the final bank holds
    // a vector that the consumer refuses.
    assign w_advance   = !r_v[STAGES-1] || i_out_ready;
    assign w_cfg_ready = (r_v == '0) && !i_in_valid;
    assign w_cfg_take  = i_cfg_valid && w_cfg_ready;
    assign w_in_take   = i_in_valid && o_in_ready;

    assign o_cfg_ready = w_cfg_ready;
    assign o_in_ready  = w_advance && !w_cfg_take;
    assign o_out_valid = r_v[STAGES-1];
    assign o_out_data  = r_data[STAGES-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ctrl <= '0;
        end else if (w_cfg_take) begin
            r_ctrl <= i_cfg_ctrl;
        end
    end

`ifdef BENES_INV_EN
    logic r_inv;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inv <= 1'b0;
        end else if (w_cfg_take) begin
            r_inv <= i_cfg_inv;
        end
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_v <= '0;
        end else if (w_advance) begin
            r_v <= {r_v[STAGES-2:0], w_in_take};
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int unsigned MIRROR = STAGES - 1 - s;
        // The gap sequence is symmetric: 1, 2, ..., SIZE/2, ..., 2, 1.
        localparam int unsigned GAP    = 1 << ((s < MIRROR) ? s : MIRROR);

        logic [HALF-1:0]  w_sel;
        logic [VEC_W-1:0] w_in;
        logic [VEC_W-1:0] w_out;

`ifdef BENES_INV_EN
        // Mirroring the slice order runs the same swaps in reverse order. This gives
        // the inverse permutation, and the gaps still line up.
        assign w_sel = r_inv ? r_ctrl[MIRROR*HALF +: HALF] : r_ctrl[s*HALF +: HALF];
`else
        assign w_sel = r_ctrl[s*HALF +: HALF];
`endif

        if (s == 0) begin : g_first
            assign w_in = i_in_data;
        end else begin : g_next
            assign w_in = r_data[s-1];
        end

        // Switch j pairs lanes P and P+GAP. Together the switches cover every lane once.
        for (genvar j = 0; j < HALF; j++) begin : g_sw
            localparam int unsigned P = (j % GAP) + 2 * GAP * (j / GAP);
            localparam int unsigned Q = P + GAP;

            assign w_out[P*DATA_W +: DATA_W] = w_sel[j] ? w_in[Q*DATA_W +: DATA_W]
                                                        : w_in[P*DATA_W +: DATA_W];
            assign w_out[Q*DATA_W +: DATA_W] = w_sel[j] ? w_in[P*DATA_W +: DATA_W]
                                                        : w_in[Q*DATA_W +: DATA_W];
        end

        // Only the final bank must read as zero after reset. The others are cleared too
        // so that every bank shares one clocking style.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_data[s] <= '0;
            end else if (w_advance) begin
                r_data[s] <= w_out;
            end
        end
    end

endmodule

// File: tb/tb_benes_perm_apply.sv
`timescale 1ns/1ps
module tb_benes_perm_apply;

    localparam int unsigned SIZE     = 32;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned TAGWIDTH = $clog2(SIZE);
    localparam int unsigned STAGES   = 2 * TAGWIDTH - 1;
    localparam int unsigned HALF     = SIZE / 2;
    localparam int unsigned BITWIDTH = STAGES * HALF;
    localparam int unsigned VEC_W    = SIZE * DATA_W;

    typedef logic [VEC_W-1:0]    vec_t;
    typedef logic [BITWIDTH-1:0] ctrl_t;
    typedef int                  idx_t [SIZE];

    logic  clk;
    logic  rst;
    logic  cfg_valid;
    logic  cfg_ready;
    ctrl_t cfg_ctrl;
    logic  cfg_inv;
    logic  in_valid;
    logic  in_ready;
    vec_t  in_data;
    logic  out_valid;
    logic  out_ready;
    vec_t  out_data;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;

    benes_perm_apply #(
        .SIZE   (SIZE),
        .DATA_W (DATA_W)
    ) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cfg_valid (cfg_valid),
        .o_cfg_ready (cfg_ready),
        .i_cfg_ctrl  (cfg_ctrl),
`ifdef BENES_INV_EN
        .i_cfg_inv   (cfg_inv),
`endif
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: run the swap sequence on lane indices. The result idx[i] is the input
    // lane that lands in output lane i.
    function automatic idx_t perm_index(input ctrl_t c);
        idx_t ix;
        int   g;
        int   p;
        int   t;
        for (int i = 0; i < SIZE; i++) ix[i] = i;
        for (int s = 0; s < STAGES; s++) begin
            g = 1 << ((s < STAGES - 1 - s) ? s : STAGES - 1 - s);
            for (int j = 0; j < HALF; j++) begin
                if (c[s*HALF + j]) begin
                    p         = (j % g) + 2 * g * (j / g);
                    t         = ix[p];
                    ix[p]     = ix[p + g];
                    ix[p + g] = t;
                end
            end
        end
        return ix;
    endfunction

    function automatic vec_t model(input ctrl_t c, input bit inv, input vec_t d);
        idx_t ix;
        vec_t o;
        ix = perm_index(c);
        o  = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (!inv) o[i*DATA_W +: DATA_W] = d[ix[i]*DATA_W +: DATA_W];
            else      o[ix[i]*DATA_W +: DATA_W] = d[i*DATA_W +: DATA_W];
        end
        return o;
    endfunction

    function automatic vec_t iota_vec();
        vec_t v;
        for (int i = 0; i < SIZE; i++) v[i*DATA_W +: DATA_W] = DATA_W'(i);
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int k = 0; k < VEC_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic ctrl_t rand_ctrl();
        ctrl_t c;
        for (int i = 0; i < BITWIDTH; i++) c[i] = 1'($urandom_range(0, 1));
        return c;
    endfunction

    // Scoreboard: a vector's expected output is computed with the control word that
    // is active when the vector is accepted.
    vec_t  exp_q [$];
    ctrl_t m_ctrl;
    bit    m_inv;
    bit    prev_stall;
    vec_t  prev_data;
    vec_t  exp_v;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_ctrl     = '0;
            m_inv      = 1'b0;
            prev_stall = 1'b0;
        end else begin
            checks++;
            if (cfg_ready !== ((exp_q.size() == 0) && !in_valid)) begin
                errors++;
                $display("FAIL cfg_ready: got %b want %b (in flight %0d)", cfg_ready,
                         (exp_q.size() == 0) && !in_valid, exp_q.size());
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: valid %b data %h want %h", out_valid, out_data,
                             prev_data);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b0) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready: got %b want 0", in_ready);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                n_out++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_out: got %h with nothing in flight", out_data);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (out_data !== exp_v) begin
                        errors++;
                        $display("FAIL out_data: got %h want %h", out_data, exp_v);
                    end
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) exp_q.push_back(model(m_ctrl, m_inv, in_data));
            if (cfg_valid === 1'b1 && cfg_ready === 1'b1) begin
                m_ctrl = cfg_ctrl;
`ifdef BENES_INV_EN
                m_inv = cfg_inv;
`else
                m_inv = 1'b0;
`endif
            end
            prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_data  = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg_valid = 1'b0; cfg_ctrl = '0; cfg_inv = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic load_cfg(input ctrl_t c, input bit inv, output bit ok);
        ok = 1'b0; in_valid = 1'b0; cfg_ctrl = c; cfg_inv = inv; cfg_valid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            ok = cfg_ready;
            tick();
            if (ok) break;
        end
        cfg_valid = 1'b0;
    endtask

    // Offers one vector, then waits for the next output; ok=0 if either wait times out.
    task automatic send_and_get(input vec_t d, output vec_t o, output bit ok);
        bit acc;
        acc = 1'b0; ok = 1'b0; o = '0; in_data = d; in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) break;
        end
        in_valid = 1'b0;
        if (acc) begin
            for (int n = 0; n < 40; n++) begin
                if (out_valid) begin
                    o  = out_data;
                    ok = 1'b1;
                    tick();
                    break;
                end
                tick();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_valid = 1'b0; cfg_ctrl = '0; cfg_inv = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        tick();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_identity_stream();
        int first;
        int last;
        int nv;
        first = -1; last = -1; nv = 0;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            in_valid = (c < 20);
            in_data  = iota_vec();
            if (c < 20) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready: got %b want 1", in_ready); end
            end
            tick();
            if (out_valid) begin
                if (first < 0) first = c + 1;
                last = c + 1;
                nv++;
                checks++;
                if (out_data !== iota_vec()) begin errors++; $display("FAIL identity_data: got %h want %h", out_data, iota_vec()); end
            end
        end
        in_valid = 1'b0;
        checks++; if (first !== STAGES) begin errors++; $display("FAIL latency: got %0d want %0d", first, STAGES); end
        checks++; if (nv !== 20) begin errors++; $display("FAIL stream_count: got %0d want 20", nv); end
        checks++; if (last - first !== 19) begin errors++; $display("FAIL throughput_span: got %0d want 19", last - first); end
    endtask

    task automatic test_all_ones();
        bit   ok;
        vec_t o;
        vec_t d;
        vec_t e;
        do_reset();
        load_cfg('1, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ones_cfg_timeout: got 0 want 1"); end
        for (int r = 0; r < 2; r++) begin
            d = (r == 0) ? iota_vec() : rand_vec();
            for (int i = 0; i < SIZE; i++) e[i*DATA_W +: DATA_W] = d[(i ^ HALF)*DATA_W +: DATA_W];
            send_and_get(d, o, ok);
            checks++;
            if (!ok || o !== e) begin errors++; $display("FAIL all_ones_%0d: got %h want %h ok %b", r, o, e, ok); end
        end
    endtask

    task automatic test_two_bits();
        bit    ok;
        vec_t  o;
        vec_t  e;
        ctrl_t c;
        do_reset();
        c = '0; c[0] = 1'b1; c[HALF] = 1'b1;
        load_cfg(c, 1'b0, ok);
        e = iota_vec();
        e[0 +: DATA_W] = DATA_W'(2); e[DATA_W +: DATA_W] = DATA_W'(0); e[2*DATA_W +: DATA_W] = DATA_W'(1);
        send_and_get(iota_vec(), o, ok);
        checks++;
        if (!ok || o !== e) begin errors++; $display("FAIL two_bits_fwd: got %h want %h ok %b", o, e, ok); end
`ifdef BENES_INV_EN
        load_cfg(c, 1'b1, ok);
        e = iota_vec();
        e[0 +: DATA_W] = DATA_W'(1); e[DATA_W +: DATA_W] = DATA_W'(2); e[2*DATA_W +: DATA_W] = DATA_W'(0);
        send_and_get(iota_vec(), o, ok);
        checks++;
        if (!ok || o !== e) begin errors++; $display("FAIL two_bits_inv: got %h want %h ok %b", o, e, ok); end
`endif
    endtask

    task automatic test_backpressure();
        bit   ok;
        int   acc;
        int   n0;
        vec_t v [5];
        do_reset();
        load_cfg(rand_ctrl(), 1'b0, ok);
        for (int i = 0; i < 5; i++) v[i] = rand_vec();
        acc = 0; n0 = n_out;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 10 && c <= 13);
            in_valid  = (acc < 4 && c < 4) || (acc == 4 && c >= 10);
            in_data   = v[(acc < 5) ? acc : 4];
            @(negedge clk);
            if (c >= 10 && c <= 13) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready); end
            end
            if (in_valid && in_ready) acc++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (acc !== 5) begin errors++; $display("FAIL bp_accepted: got %0d want 5", acc); end
        checks++; if (n_out - n0 !== 5) begin errors++; $display("FAIL bp_delivered: got %0d want 5", n_out - n0); end
    endtask

    task automatic test_cfg_inflight();
        bit    ok;
        int    rise;
        vec_t  o;
        ctrl_t a;
        ctrl_t b;
        a = rand_ctrl(); b = rand_ctrl();
        do_reset();
        load_cfg(a, 1'b0, ok);
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_data = rand_vec();
            tick();
        end
        // Last vector was captured at edge 3. It leaves the final bank at edge 3+STAGES.
        in_valid = 1'b0; cfg_ctrl = b; cfg_valid = 1'b1; rise = -1;
        for (int c = 3; c < 40; c++) begin
            @(negedge clk);
            if (cfg_ready && rise < 0) rise = c;
            tick();
            if (rise >= 0) break;
        end
        cfg_valid = 1'b0;
        checks++; if (rise !== 3 + STAGES) begin errors++; $display("FAIL cfg_rise: got %0d want %0d", rise, 3 + STAGES); end
        send_and_get(iota_vec(), o, ok);
        checks++; if (!ok || o !== model(b, 1'b0, iota_vec())) begin errors++; $display("FAIL cfg_new_applies: got %h want %h", o, model(b, 1'b0, iota_vec())); end
        // Back-to-back loads: the second word wins.
        load_cfg(a, 1'b0, ok);
        load_cfg(b, 1'b0, ok);
        send_and_get(iota_vec(), o, ok);
        checks++; if (!ok || o !== model(b, 1'b0, iota_vec())) begin errors++; $display("FAIL cfg_last_wins: got %h want %h", o, model(b, 1'b0, iota_vec())); end
    endtask

    task automatic test_reset_midstream();
        bit   ok;
        int   n0;
        vec_t d;
        vec_t o;
        do_reset();
        load_cfg(rand_ctrl(), 1'b0, ok);
        n0 = n_out;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; in_data = rand_vec();
            tick();
        end
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL midrst_cfg_ready: got %b want 1", cfg_ready); end
        d = rand_vec();
        send_and_get(d, o, ok);
        checks++; if (!ok || o !== d) begin errors++; $display("FAIL midrst_identity: got %h want %h", o, d); end
        checks++; if (n_out - n0 !== 1) begin errors++; $display("FAIL midrst_discard: got %0d want 1", n_out - n0); end
    endtask

    task automatic test_random();
        bit ok;
        bit inv;
        int got;
        int cyc;
        int n0;
        do_reset();
        n0 = n_out;
        for (int e = 0; e < 20; e++) begin
            out_ready = 1'b1;
            inv = 1'b0;
`ifdef BENES_INV_EN
            inv = 1'($urandom_range(0, 1));
`endif
            load_cfg(rand_ctrl(), inv, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand_cfg_timeout e%0d: got 0 want 1", e); end
            got = 0; cyc = 0;
            while (got < 50 && cyc < 1000) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = rand_vec();
                out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (in_valid && in_ready) got++;
                tick();
                cyc++;
            end
            in_valid = 1'b0;
            checks++; if (got !== 50) begin errors++; $display("FAIL rand_accept e%0d: got %0d want 50", e, got); end
        end
        out_ready = 1'b1;
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick();
        tick();
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rand_drain: got %0d left want 0", exp_q.size()); end
        checks++; if (n_out - n0 !== 1000) begin errors++; $display("FAIL rand_count: got %0d want 1000", n_out - n0); end
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_ctrl = '0; cfg_inv = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        test_reset();
        test_identity_stream();
        test_all_ones();
        test_two_bits();
        test_backpressure();
        test_cfg_inflight();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
